// File: rtl/l2_req_arbiter.sv
// l2_req_arbiter: shares one L2 port between the L1 I-side and D-side miss paths,
// round-robin on ties, latching the winner's operands until l2_resp.
module l2_req_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp,
  output logic [CNT_W-1:0]  conflict_count
);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
  state_t              state_q, state_d;
  logic                last_d_q, last_d_d;
  logic                op_wr_q, op_wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                i_req, d_req, grant_i, grant_d, busy;
  always_comb begin
    i_req    = i_read;
    d_req    = d_read | d_write;
    grant_i  = i_req & (~d_req | last_d_q);
    grant_d  = d_req & (~i_req | ~last_d_q);
    state_d  = state_q;
    last_d_d = last_d_q;
    op_wr_d  = op_wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    if (state_q == IDLE) begin
      if (grant_i) begin
        state_d  = BUSY_I;
        last_d_d = 1'b0;
        op_wr_d  = 1'b0;
        addr_d   = i_addr;
      end
      if (grant_d) begin
        state_d  = BUSY_D;
        last_d_d = 1'b1;
        op_wr_d  = d_write;
        addr_d   = d_addr;
        wdata_d  = d_wdata;
      end
      if (i_req && d_req && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end else if (l2_resp) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      last_d_q <= 1'b1;
      op_wr_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      op_wr_q  <= op_wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
    end
  end
  assign busy           = state_q != IDLE;
  assign l2_read        = busy & ~op_wr_q;
  assign l2_write       = busy & op_wr_q;
  assign l2_addr        = busy ? addr_q : '0;
  assign l2_wdata       = busy ? wdata_q : '0;
  assign i_resp         = (state_q == BUSY_I) & l2_resp;
  assign d_resp         = (state_q == BUSY_D) & l2_resp;
  // read data mirrors L2 but is forced low while reset is asserted
  assign i_rdata        = rst ? l2_rdata : '0;
  assign d_rdata        = rst ? l2_rdata : '0;
  assign conflict_count = cnt_q;
endmodule

// File: tb/tb_l2_req_arbiter.sv
// tb_l2_req_arbiter: directed scenarios plus random traffic, checked every cycle
// against a behavioural model of the arbiter.
module tb_l2_req_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;
  localparam int CW = 8;
  logic          clk = 1'b0;
  logic          rst;
  logic          i_read, d_read, d_write, l2_resp;
  logic [AW-1:0] i_addr, d_addr;
  logic [LW-1:0] d_wdata, l2_rdata;
  logic [LW-1:0] i_rdata, d_rdata, l2_wdata;
  logic          i_resp, d_resp, l2_read, l2_write;
  logic [AW-1:0] l2_addr;
  logic [CW-1:0] conflict_count;
  int            checks = 0, failures = 0;
  l2_req_arbiter #(.ADDR_W(AW), .LINE_W(LW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .l2_read(l2_read), .l2_write(l2_write), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
    .l2_rdata(l2_rdata), .l2_resp(l2_resp), .conflict_count(conflict_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  // model: who owns the port (0 none, 1 I, 2 D), who won last, and the latched operands
  int            m_own, m_cnt;
  bit            m_last_d, m_write, m_busy;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wdata;
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_l2_read", l2_read, 0);
      chk("rst_l2_write", l2_write, 0);
      chk("rst_l2_addr", l2_addr, 0);
      chk("rst_l2_wdata", l2_wdata, 0);
      chk("rst_resp", {i_resp, d_resp}, 0);
      chk("rst_rdata", i_rdata | d_rdata, 0);
      chk("rst_cnt", conflict_count, 0);
      m_own = 0; m_last_d = 1; m_write = 0; m_addr = '0; m_wdata = '0; m_cnt = 0;
    end else begin
      m_busy = m_own != 0;
      chk("l2_read", l2_read, m_busy && !m_write);
      chk("l2_write", l2_write, m_busy && m_write);
      chk("l2_addr", l2_addr, m_busy ? m_addr : '0);
      chk("l2_wdata", l2_wdata, m_busy ? m_wdata : '0);
      chk("i_resp", i_resp, m_own == 1 && l2_resp);
      chk("d_resp", d_resp, m_own == 2 && l2_resp);
      chk("i_rdata", i_rdata, l2_rdata);
      chk("d_rdata", d_rdata, l2_rdata);
      chk("conflict_count", conflict_count, m_cnt);
      if (m_own == 0) begin
        if (i_read && (d_read || d_write)) begin
          if (m_cnt < (1 << CW) - 1) m_cnt++;
          m_own = m_last_d ? 1 : 2;
        end else if (i_read) m_own = 1;
        else if (d_read || d_write) m_own = 2;
        if (m_own == 1) begin
          m_last_d = 0; m_write = 0; m_addr = i_addr;
        end else if (m_own == 2) begin
          m_last_d = 1; m_write = d_write; m_addr = d_addr; m_wdata = d_wdata;
        end
      end else if (l2_resp) m_own = 0;
    end
  end
  logic [LW-1:0] aa, ff5;
  int            owner, w, nresp;
  bit            i_done, d_done;
  int unsigned   r;
  initial begin
    aa = {8{32'haaaa_aaaa}};
    ff5 = {8{32'h5555_5555}};
    rst = 0; i_read = 0; d_read = 0; d_write = 0; l2_resp = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; l2_rdata = '0;
    cyc(); cyc();
    rst = 1;
    chk("reset_cnt", conflict_count, 0);
    // I-only read
    i_read = 1; i_addr = 32'h1000;
    cyc();
    chk("t1_l2_read", l2_read, 1);
    chk("t1_l2_addr", l2_addr, 32'h1000);
    cyc(); cyc();
    chk("t1_l2_read_held", l2_read, 1);
    cyc();
    l2_resp = 1; l2_rdata = aa;
    #1;
    chk("t1_i_resp", i_resp, 1);
    chk("t1_i_rdata", i_rdata, aa);
    chk("t1_d_resp", d_resp, 0);
    cyc();
    l2_resp = 0; i_read = 0;
    #1;
    chk("t1_idle", l2_read, 0);
    // D-only write
    d_write = 1; d_addr = 32'h2000; d_wdata = ff5;
    cyc();
    chk("t2_l2_write", l2_write, 1);
    chk("t2_l2_read", l2_read, 0);
    chk("t2_l2_wdata", l2_wdata, ff5);
    cyc(); cyc();
    l2_resp = 1;
    #1;
    chk("t2_d_resp", d_resp, 1);
    chk("t2_i_resp", i_resp, 0);
    cyc();
    l2_resp = 0; d_write = 0;
    #1;
    chk("t2_d_resp_once", d_resp, 0);
    // simultaneous from reset: I first, then D after one idle cycle
    rst = 0;
    cyc();
    rst = 1;
    i_read = 1; d_read = 1; i_addr = 32'h100; d_addr = 32'h200;
    cyc();
    chk("t3_first_addr", l2_addr, 32'h100);
    chk("t3_cnt", conflict_count, 1);
    l2_resp = 1;
    #1;
    chk("t3_i_resp", i_resp, 1);
    cyc();
    l2_resp = 0; i_read = 0;
    chk("t3_gap", l2_read, 0);
    cyc();
    chk("t3_second_addr", l2_addr, 32'h200);
    chk("t3_second_read", l2_read, 1);
    l2_resp = 1;
    #1;
    chk("t3_d_resp", d_resp, 1);
    cyc();
    l2_resp = 0;
    // continuous contention alternates I, D, ...
    i_read = 1; d_read = 1;
    for (int k = 0; k < 6; k++) begin
      w = 0;
      while (!(l2_read | l2_write) && w < 20) begin cyc(); w++; end
      l2_resp = 1;
      #1;
      owner = i_resp ? 1 : (d_resp ? 2 : 0);
      chk("t4_rr_owner", owner, (k % 2 == 0) ? 1 : 2);
      cyc();
      l2_resp = 0;
    end
    chk("t4_cnt7", conflict_count, 7);
    l2_resp = 1;
    repeat (600) cyc();
    chk("t4_cnt_sat", conflict_count, 8'hff);
    i_read = 0; d_read = 0;
    cyc();
    l2_resp = 0;
    cyc();
    chk("t4_cnt_hold", conflict_count, 8'hff);
    // operands stay latched while the requester changes its inputs
    d_write = 1; d_addr = 32'h2000; d_wdata = ff5;
    cyc();
    chk("t5_addr", l2_addr, 32'h2000);
    d_addr = 32'h3000; d_write = 0; d_wdata = '0;
    cyc();
    chk("t5_addr_latched", l2_addr, 32'h2000);
    chk("t5_write_held", l2_write, 1);
    chk("t5_wdata_latched", l2_wdata, ff5);
    l2_resp = 1;
    #1;
    chk("t5_d_resp", d_resp, 1);
    cyc();
    #1;
    chk("t5_idle_resp", {i_resp, d_resp}, 0);
    cyc();
    l2_resp = 0;
    // asynchronous reset between edges
    i_read = 1; i_addr = 32'h4000;
    cyc();
    chk("t6_busy", l2_read, 1);
    #2;
    rst = 0;
    #1;
    chk("t6_async_read", l2_read, 0);
    chk("t6_async_addr", l2_addr, 0);
    chk("t6_async_rdata", i_rdata, 0);
    cyc();
    rst = 1;
    chk("t6_post_idle", l2_read, 0);
    cyc();
    chk("t6_reissue", l2_read, 1);
    chk("t6_reissue_addr", l2_addr, 32'h4000);
    l2_resp = 1;
    cyc();
    l2_resp = 0; i_read = 0;
    // random traffic, every cycle checked by the model
    i_done = 0; d_done = 0; nresp = 0;
    for (int n = 0; n < 3000; n++) begin
      cyc();
      if (!i_read || i_done) begin
        i_read = ($urandom % 3) == 0; i_addr = $urandom;
      end else if ($urandom % 16 == 0) i_addr = $urandom;
      else if ($urandom % 40 == 0) i_read = 0;
      if (!(d_read || d_write) || d_done) begin
        r = $urandom % 8;
        d_read = r inside {0, 1, 4};
        d_write = r inside {2, 3, 4};
        d_addr = $urandom;
        for (int k = 0; k < 8; k++) d_wdata[k*32 +: 32] = $urandom;
      end else if ($urandom % 16 == 0) d_addr = $urandom;
      else if ($urandom % 40 == 0) begin d_read = 0; d_write = 0; end
      l2_resp = !l2_resp && ((l2_read | l2_write) ? ($urandom % 3 == 0) : ($urandom % 8 == 0));
      for (int k = 0; k < 8; k++) l2_rdata[k*32 +: 32] = $urandom;
      #1;
      i_done = i_resp; d_done = d_resp;
      if (i_resp || d_resp) nresp++;
    end
    chk("rand_activity", nresp > 100, 1);
    i_read = 0; d_read = 0; d_write = 0; l2_resp = 1;
    cyc();
    l2_resp = 0;
    cyc(); cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
